// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   state_t     - controller state encoding (2'd3 is unused and recovers to IDLE)
//   PORT0/PORT1 - requester identifiers used for grant bookkeeping
//   other_port  - returns the opposite requester id
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   eligible[1:0] - per-port eligibility this cycle
//   last_grant    - port granted most recently
//   valid         - at least one port is eligible
//   pick          - chosen port id (meaningful only when valid)
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |eligible;
    pick  = PORT0;
    if (&eligible) begin
      // Tie: the port that did not win last time goes next.
      pick = other_port(last_grant);
    end else if (eligible[1]) begin
      pick = PORT1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises two requesters onto one single-port synchronous
// RAM. Grants round-robin, drives registered RAM controls and returns read data
// with a one-cycle ack pulse. One access takes IDLE -> ISSUE -> CAPTURE.
//   clk, reset           - clock, synchronous active-high reset
//   req/we/addr/wdata N  - requester N access (req held until ackN)
//   ackN, rdataN         - one-cycle completion pulse, captured read data (held)
//   mem_enable/we/addr/di- registered RAM controls
//   mem_do               - RAM read data, valid the cycle after the sampling edge
//   busy                 - high whenever the controller is not IDLE
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic              is_write, is_write_nxt;
  logic              enable_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] di_nxt;
  logic              ack0_nxt, ack1_nxt;
  logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
  logic              busy_nxt;

  logic [1:0]        eligible;
  logic              pick_valid;
  logic              pick;

  // A port whose ack is showing this cycle is masked, so a held request is
  // treated as a new one only from the following cycle.
  assign eligible = {req1 & ~ack1, req0 & ~ack0};

  rr_pick2 u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= PORT0;
      last_grant <= PORT1;
      is_write   <= 1'b0;
      mem_enable <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      is_write   <= is_write_nxt;
      mem_enable <= enable_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_di     <= di_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    is_write_nxt   = is_write;
    enable_nxt     = mem_enable;
    we_nxt         = mem_we;
    addr_nxt       = mem_addr;
    di_nxt         = mem_di;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          enable_nxt     = 1'b1;
          we_nxt         = pick ? we1 : we0;
          addr_nxt       = pick ? addr1 : addr0;
          di_nxt         = pick ? wdata1 : wdata0;
          is_write_nxt   = pick ? we1 : we0;
          grant_nxt      = pick;
          last_grant_nxt = pick;
          state_nxt      = ISSUE;
        end else begin
          enable_nxt = 1'b0;
          we_nxt     = 1'b0;
        end
      end
      ISSUE: begin
        enable_nxt = 1'b0;
        we_nxt     = 1'b0;
        state_nxt  = CAPTURE;
      end
      CAPTURE: begin
        if (grant == PORT0) begin
          ack0_nxt = 1'b1;
          if (!is_write) rdata0_nxt = mem_do;
        end else begin
          ack1_nxt = 1'b1;
          if (!is_write) rdata1_nxt = mem_do;
        end
        state_nxt = IDLE;
      end
      default: begin
        enable_nxt = 1'b0;
        we_nxt     = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       mem_enable, mem_we;
  logic [7:0] mem_addr, mem_di;
  logic [7:0] mem_do;
  logic       busy;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .ack0       (ack0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .ack1       (ack1),
    .rdata1     (rdata1),
    .mem_enable (mem_enable),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .mem_do     (mem_do),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM model.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_we) ram[mem_addr] <= mem_di;
      else        mem_do <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one access on port p, return cycles until its ack, write-strobe
  // cycles seen, acks seen on the other port and the captured rdata.
  task automatic access(input logic p, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output int lat, output int wecnt,
                        output int othack, output logic [7:0] rd);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    lat = 0; wecnt = 0; othack = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      lat = i;
      if (mem_we) wecnt++;
      if (p ? ack0 : ack1) othack++;
      if (p ? ack1 : ack0) begin
        rd = p ? rdata1 : rdata0;
        break;
      end
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, wecnt, oth, t0, t1, n, last, busy_err, long0, long1, cnt;
    logic [7:0] rd, r0, r1;
    logic prev0, prev1;

    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_en", mem_enable, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_di", mem_di, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Port 0 write then read.
    access(1'b0, 1'b1, 8'd0, 8'd64, lat, wecnt, oth, rd);
    check("p0w_lat", lat, 3);
    check("p0w_we_cycles", wecnt, 1);
    access(1'b0, 1'b0, 8'd0, 8'd0, lat, wecnt, oth, rd);
    check("p0r_lat", lat, 3);
    check("p0r_we_cycles", wecnt, 0);
    check("p0r_rdata", rd, 64);

    // Port 1 write then read; port 0 untouched.
    access(1'b1, 1'b1, 8'd1, 8'd42, lat, wecnt, oth, rd);
    check("p1w_lat", lat, 3);
    check("p1w_ack0", oth, 0);
    check("p1w_rdata1", rdata1, 0);
    access(1'b1, 1'b0, 8'd1, 8'd0, lat, wecnt, oth, rd);
    check("p1r_lat", lat, 3);
    check("p1r_rdata", rd, 42);
    check("p1r_ack0", oth, 0);
    check("p1r_rdata0", rdata0, 64);

    // Simultaneous requests right after reset: port 0 first.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 8'd0;
    req1 = 1; we1 = 0; addr1 = 8'd1;
    t0 = -1; t1 = -1; r0 = '0; r1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack0 && t0 < 0) begin t0 = i; r0 = rdata0; req0 = 0; end
      if (ack1 && t1 < 0) begin t1 = i; r1 = rdata1; req1 = 0; end
      if (t0 > 0 && t1 > 0) break;
    end
    check("tie_ack0_time", t0, 3);
    check("tie_ack1_time", t1, 6);
    check("tie_rdata0", r0, 64);
    check("tie_rdata1", r1, 42);
    @(negedge clk);

    // Both requests held: 12 alternating accesses.
    req0 = 1; we0 = 0; addr0 = 8'd0;
    req1 = 1; we1 = 0; addr1 = 8'd1;
    n = 0; last = 0; busy_err = 0; long0 = 0; long1 = 0;
    prev0 = 0; prev1 = 0;
    for (int i = 1; i <= 60 && n < 12; i++) begin
      @(negedge clk);
      if (ack0 && prev0) long0++;
      if (ack1 && prev1) long1++;
      prev0 = ack0; prev1 = ack1;
      if (busy !== !(ack0 | ack1)) busy_err++;
      if (ack0 | ack1) begin
        check("hold_port", ack1, n % 2);
        check("hold_gap", i - last, 3);
        last = i;
        n++;
        if (n == 12) begin req0 = 0; req1 = 0; end
      end
    end
    check("hold_count", n, 12);
    check("hold_long_ack0", long0, 0);
    check("hold_long_ack1", long1, 0);
    check("hold_busy", busy_err, 0);
    check("hold_rdata0", rdata0, 64);
    check("hold_rdata1", rdata1, 42);
    @(negedge clk);

    // Reset on the ISSUE edge of a port 1 write.
    req1 = 1; we1 = 1; addr1 = 8'd5; wdata1 = 8'd99;
    @(negedge clk);
    check("iss_en", mem_enable, 1);
    check("iss_we", mem_we, 1);
    check("iss_addr", mem_addr, 5);
    check("iss_di", mem_di, 99);
    reset = 1'b1;
    req1 = 0; we1 = 0;
    @(negedge clk);
    check("iss_rst_ack1", ack1, 0);
    check("iss_rst_en", mem_enable, 0);
    check("iss_rst_we", mem_we, 0);
    check("iss_rst_busy", busy, 0);
    check("iss_rst_rdata0", rdata0, 0);
    check("iss_rst_rdata1", rdata1, 0);
    check("iss_rst_addr", mem_addr, 0);
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack1) cnt++;
    end
    check("iss_no_ack1", cnt, 0);
    access(1'b1, 1'b0, 8'd5, 8'd0, lat, wecnt, oth, rd);
    check("iss_readback_lat", lat, 3);
    check("iss_readback", rd, 99);

    // Reset during CAPTURE of a port 0 read.
    access(1'b0, 1'b0, 8'd0, 8'd0, lat, wecnt, oth, rd);
    check("cap_pre_rdata0", rd, 64);
    req0 = 1; we0 = 0; addr0 = 8'd1;
    @(negedge clk);
    @(negedge clk);
    check("cap_busy", busy, 1);
    check("cap_ack0_early", ack0, 0);
    reset = 1'b1;
    req0 = 0;
    @(negedge clk);
    check("cap_rst_ack0", ack0, 0);
    check("cap_rst_rdata0", rdata0, 0);
    reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_enable | ack0 | ack1) cnt++;
    end
    check("cap_quiet", cnt, 0);
    check("cap_final_rdata0", rdata0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
